ctu_jtag_seq: RTL and testbench

JTAG master sequencer for the CTU DFT logic. It accepts reset, IR-shift, DR-shift and idle commands over a valid/ready interface and generates TCK/TMS/TDI for a downstream IEEE 1149.1 TAP such as the CTU DFT TAP. It tracks the TAP state implicitly through a fixed TMS walk per command and captures TDO during shifts. It lets on-chip agents, such as BIST or debug requesters, drive the TAP without an external tester.

---
 rtl/ctu_jtag_seq_pkg.sv | 36 +++
 rtl/ctu_jtag_seq_tckgen.sv | 38 +++
 rtl/ctu_jtag_seq.sv | 217 +++++++++++++++++++++
 tb/tb_ctu_jtag_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctu_jtag_seq_pkg.sv
// Shared encodings for the CTU JTAG sequencer: command ops, FSM states and fixed TMS walks.
package ctu_jtag_seq_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_IR    = 2'd1,
    OP_DR    = 2'd2,
    OP_IDLE  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_AUTORST = 3'd0,
    ST_IDLE    = 3'd1,
    ST_PRE     = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_POST    = 3'd4,
    ST_RUN     = 3'd5
  } state_e;

  // TMS walks, bit k is the TMS value of step k
  localparam int          RST_LEN    = 6;
  localparam logic [5:0]  RST_TMS    = 6'b01_1111;
  localparam int          IR_PRE_LEN = 4;
  localparam logic [3:0]  IR_PRE_TMS = 4'b0011;
  localparam int          DR_PRE_LEN = 3;
  localparam logic [3:0]  DR_PRE_TMS = 4'b0001;
  localparam int          POST_LEN   = 2;
  localparam logic [1:0]  POST_TMS   = 2'b01;

  localparam int          STEP_W     = 3;

  function automatic logic [STEP_W-1:0] pre_last(input logic is_ir);
    return is_ir ? STEP_W'(IR_PRE_LEN - 1) : STEP_W'(DR_PRE_LEN - 1);
  endfunction

endpackage

// File: rtl/ctu_jtag_seq_tckgen.sv
// TCK divider: TCK_DIV clk cycles per half-period, held low while disabled.
// Rise/fall strobes are high in the cycle whose closing clk edge moves TCK.
module ctu_jtag_seq_tckgen #(
  parameter int TCK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_l,
  input  logic i_en,
  output logic o_tck,
  output logic o_tck_rise,
  output logic o_tck_fall
);

  localparam int CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tck;
  logic             w_half;

  assign w_half     = i_en & (r_cnt == CNT_LAST);
  assign o_tck_rise = w_half & ~r_tck;
  assign o_tck_fall = w_half & r_tck;
  assign o_tck      = r_tck;

  always_ff @(posedge i_clk) begin
    if (!i_rst_l || !i_en) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (w_half) begin
      r_cnt <= '0;
      r_tck <= ~r_tck;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ctu_jtag_seq.sv
// JTAG master sequencer: RESET/IR/DR/IDLE commands become fixed TMS walks with TDI shift and TDO capture.
// Latency: step 0 drives the cycle after accept; completion (rsp_vld) at cycle 1+2*S*TCK_DIV.
// Backpressure: cmd_rdy high only while idle; capture register built when CTU_JTAG_SEQ_CAPTURE_EN is defined.
module ctu_jtag_seq
  import ctu_jtag_seq_pkg::*;
#(
  parameter int TCK_DIV = 2,
  parameter int DATA_W  = 64,
  parameter int LEN_W   = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_l,
  input  logic              i_cmd_vld,
  output logic              o_cmd_rdy,
  input  logic [1:0]        i_cmd_op,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_rsp_vld,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_jtag_tck,
  output logic              o_jtag_tms,
  output logic              o_jtag_tdi,
  input  logic              i_jtag_tdo
);

  state_e              r_state;
  logic                r_tck_en;
  logic                r_is_ir;
  logic                r_rsp_en;
  logic [STEP_W-1:0]   r_step;
  logic [LEN_W-1:0]    r_bit;
  logic [DATA_W-1:0]   r_data;
  logic                r_cmd_rdy;
  logic                r_rsp_vld;
  logic                r_tms;
  logic                r_tdi;

  logic                w_accept;
  logic                w_tck_rise;
  logic                w_tck_fall;
  logic                w_done;
  logic [STEP_W-1:0]   w_step_nxt;
  logic [3:0]          w_pre_pat;

  ctu_jtag_seq_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .i_clk      (i_clk),
    .i_rst_l    (i_rst_l),
    .i_en       (r_tck_en),
    .o_tck      (o_jtag_tck),
    .o_tck_rise (w_tck_rise),
    .o_tck_fall (w_tck_fall)
  );

  assign w_accept   = r_cmd_rdy & i_cmd_vld;
  assign w_step_nxt = r_step + STEP_W'(1);
  assign w_pre_pat  = r_is_ir ? IR_PRE_TMS : DR_PRE_TMS;

  // The falling edge that closes the last step of a walk is the completion edge
  assign w_done = w_tck_fall &
                  (((r_state == ST_AUTORST) && (r_step == STEP_W'(RST_LEN - 1))) ||
                   ((r_state == ST_POST)    && (r_step == STEP_W'(POST_LEN - 1))) ||
                   ((r_state == ST_RUN)     && (r_bit == '0)));

  always_ff @(posedge i_clk) begin
    if (!i_rst_l) begin
      r_state   <= ST_AUTORST;
      r_tck_en  <= 1'b0;
      r_is_ir   <= 1'b0;
      r_rsp_en  <= 1'b0;
      r_step    <= '0;
      r_bit     <= '0;
      r_data    <= '0;
      r_cmd_rdy <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_tms     <= 1'b1;
      r_tdi     <= 1'b0;
    end else begin
      r_rsp_vld <= 1'b0;
      if (w_done) begin
        r_state   <= ST_IDLE;
        r_tck_en  <= 1'b0;
        r_cmd_rdy <= 1'b1;
        r_rsp_vld <= r_rsp_en;
        r_tms     <= 1'b0;
        r_tdi     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_cmd_rdy <= 1'b0;
              r_tck_en  <= 1'b1;
              r_rsp_en  <= 1'b1;
              r_step    <= '0;
              r_bit     <= i_cmd_len;
              r_data    <= i_cmd_data;
              r_is_ir   <= (op_e'(i_cmd_op) == OP_IR);
              r_tdi     <= 1'b0;
              case (op_e'(i_cmd_op))
                OP_RESET: begin
                  r_state <= ST_AUTORST;
                  r_tms   <= RST_TMS[0];
                end
                OP_IR, OP_DR: begin
                  r_state <= ST_PRE;
                  r_tms   <= 1'b1;
                end
                default: begin
                  r_state <= ST_RUN;
                  r_tms   <= 1'b0;
                end
              endcase
            end
          end
          ST_AUTORST: begin
            // First cycle out of reset only arms the divider so step 0 gets a full low phase
            if (!r_tck_en) begin
              r_tck_en <= 1'b1;
            end else if (w_tck_fall) begin
              r_step <= w_step_nxt;
              r_tms  <= RST_TMS[w_step_nxt];
            end
          end
          ST_PRE: begin
            if (w_tck_fall) begin
              if (r_step == pre_last(r_is_ir)) begin
                r_state <= ST_SHIFT;
                r_tms   <= (r_bit == '0);
                r_tdi   <= r_data[0];
                r_data  <= r_data >> 1;
              end else begin
                r_step <= w_step_nxt;
                r_tms  <= w_pre_pat[w_step_nxt[1:0]];
              end
            end
          end
          ST_SHIFT: begin
            if (w_tck_fall) begin
              if (r_bit == '0) begin
                r_state <= ST_POST;
                r_step  <= '0;
                r_tms   <= POST_TMS[0];
                r_tdi   <= 1'b0;
              end else begin
                r_bit  <= r_bit - LEN_W'(1);
                r_tms  <= (r_bit == LEN_W'(1));
                r_tdi  <= r_data[0];
                r_data <= r_data >> 1;
              end
            end
          end
          ST_POST: begin
            if (w_tck_fall) begin
              r_step <= w_step_nxt;
              r_tms  <= POST_TMS[1];
            end
          end
          ST_RUN: begin
            if (w_tck_fall) begin
              r_bit <= r_bit - LEN_W'(1);
            end
          end
          default: begin
            r_state  <= ST_AUTORST;
            r_tck_en <= 1'b0;
            r_rsp_en <= 1'b0;
            r_step   <= '0;
            r_tms    <= 1'b1;
            r_tdi    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_cmd_rdy  = r_cmd_rdy;
  assign o_rsp_vld  = r_rsp_vld;
  assign o_jtag_tms = r_tms;
  assign o_jtag_tdi = r_tdi;

`ifdef CTU_JTAG_SEQ_CAPTURE_EN
  logic [DATA_W-1:0] r_cap;
  logic [DATA_W-1:0] r_rsp_data;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_idx;

  // Shift bit index recovered from the down-counting bit counter
  assign w_idx = r_len - r_bit;

  always_ff @(posedge i_clk) begin
    if (!i_rst_l) begin
      r_cap      <= '0;
      r_rsp_data <= '0;
      r_len      <= '0;
    end else begin
      if (w_accept) begin
        r_cap <= '0;
        r_len <= i_cmd_len;
      end else if (w_tck_rise && (r_state == ST_SHIFT)) begin
        r_cap[w_idx] <= i_jtag_tdo;
      end
      if (w_done) begin
        r_rsp_data <= (r_state == ST_POST) ? r_cap : '0;
      end
    end
  end

  assign o_rsp_data = r_rsp_data;
`else
  logic w_unused;

  assign w_unused   = ^{i_jtag_tdo, w_tck_rise};
  assign o_rsp_data = '0;
`endif

endmodule

// File: tb/tb_ctu_jtag_seq.sv
// Directed bench for ctu_jtag_seq at TCK_DIV=2: walk timing, TMS/TDI patterns and TDO capture via loopback.
module tb_ctu_jtag_seq;

  localparam int TCK_DIV = 2;
  localparam int DATA_W  = 64;
  localparam int LEN_W   = 6;

  logic              clk = 1'b0;
  logic              rst_l;
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [1:0]        cmd_op;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_vld;
  logic [DATA_W-1:0] rsp_data;
  logic              tck, tms, tdi, tdo;
  logic              tdo_inv;

  int checks   = 0;
  int failures = 0;

  int           t_done, t_first_rise, t_nrise, t_vld_cnt;
  logic [127:0] t_tms, t_tdi;
  logic [63:0]  t_rsp;
  logic         t_tck_done, t_vld_done;

  always #5 clk = ~clk;

  assign tdo = tdi ^ tdo_inv;

  ctu_jtag_seq #(
    .TCK_DIV (TCK_DIV),
    .DATA_W  (DATA_W),
    .LEN_W   (LEN_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_l    (rst_l),
    .i_cmd_vld  (cmd_vld),
    .o_cmd_rdy  (cmd_rdy),
    .i_cmd_op   (cmd_op),
    .i_cmd_len  (cmd_len),
    .i_cmd_data (cmd_data),
    .o_rsp_vld  (rsp_vld),
    .o_rsp_data (rsp_data),
    .o_jtag_tck (tck),
    .o_jtag_tms (tms),
    .o_jtag_tdi (tdi),
    .i_jtag_tdo (tdo)
  );

  function automatic logic [63:0] exp_cap(input logic [63:0] v);
`ifdef CTU_JTAG_SEQ_CAPTURE_EN
    return v;
`else
    return 64'd0 & v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of cycle 1; samples each negedge until cmd_rdy returns
  task automatic track(input int max_cyc);
    logic prev;
    prev = 1'b0;
    t_done = -1; t_first_rise = -1; t_nrise = 0; t_vld_cnt = 0;
    t_tms = '0; t_tdi = '0; t_rsp = '0; t_tck_done = 1'b1; t_vld_done = 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (tck && !prev) begin
        if (t_first_rise < 0) t_first_rise = cyc;
        if (t_nrise < 128) begin
          t_tms[t_nrise] = tms;
          t_tdi[t_nrise] = tdi;
        end
        t_nrise++;
      end
      prev = tck;
      if (rsp_vld) t_vld_cnt++;
      if (cmd_rdy) begin
        t_done     = cyc;
        t_tck_done = tck;
        t_vld_done = rsp_vld;
        t_rsp      = rsp_data;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called at a negedge with cmd_rdy high; returns at the negedge of cycle 1
  task automatic send(input logic [1:0] op, input logic [LEN_W-1:0] len, input logic [63:0] data);
    cmd_vld  = 1'b1;
    cmd_op   = op;
    cmd_len  = len;
    cmd_data = data;
    @(posedge clk);
    @(negedge clk);
    cmd_vld  = 1'b0;
    cmd_op   = 2'd1;
    cmd_len  = ~len;
    cmd_data = ~data;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l = 1'b0; cmd_vld = 1'b0; cmd_op = 2'd0; cmd_len = '0; cmd_data = '0; tdo_inv = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_cmd_rdy",  cmd_rdy,  0);
    chk("rst_rsp_vld",  rsp_vld,  0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_tck",      tck,      0);
    chk("rst_tms",      tms,      1);
    chk("rst_tdi",      tdi,      0);

    // Auto-reset walk after release
    rst_l = 1'b1;
    @(negedge clk);
    track(100);
    chk("auto_done",    t_done,    25);
    chk("auto_tms",     t_tms,     128'h1F);
    chk("auto_nrise",   t_nrise,   6);
    chk("auto_no_vld",  t_vld_cnt, 0);

    // DR 8 bits, loopback
    send(2'd2, 6'd7, 64'hA5);
    track(200);
    chk("dr_done",      t_done,     53);
    chk("dr_tms",       t_tms,      128'h0C01);
    chk("dr_nrise",     t_nrise,    13);
    chk("dr_tdi",       t_tdi,      128'h528);
    chk("dr_vld",       t_vld_done, 1);
    chk("dr_tck_done",  t_tck_done, 0);
    chk("dr_vld_cnt",   t_vld_cnt,  1);
    chk("dr_rsp",       t_rsp,      exp_cap(64'hA5));

    // IR 5 bits, inverted loopback
    tdo_inv = 1'b1;
    send(2'd1, 6'd4, 64'h1E);
    track(200);
    chk("ir_done",      t_done,  45);
    chk("ir_tms",       t_tms,   128'h303);
    chk("ir_tdi",       t_tdi,   128'h1E0);
    chk("ir_rsp",       t_rsp,   exp_cap(64'h01));

    // Back-to-back: second DR held valid while the first runs
    tdo_inv  = 1'b0;
    cmd_vld  = 1'b1; cmd_op = 2'd2; cmd_len = 6'd7; cmd_data = 64'h3C;
    @(posedge clk);
    @(negedge clk);
    cmd_op = 2'd2; cmd_len = 6'd3; cmd_data = 64'h9;
    track(200);
    chk("b2b1_done",    t_done,    53);
    chk("b2b1_vld_cnt", t_vld_cnt, 1);
    chk("b2b1_rsp",     t_rsp,     exp_cap(64'h3C));
    @(posedge clk);
    @(negedge clk);
    cmd_vld = 1'b0; cmd_data = 64'hFFFF;
    track(200);
    chk("b2b2_rise",    t_first_rise, 3);
    chk("b2b2_done",    t_done,       37);
    chk("b2b2_tms",     t_tms,        128'hC1);
    chk("b2b2_nrise",   t_nrise,      9);
    chk("b2b2_rsp",     t_rsp,        exp_cap(64'h9));

    // Single-bit DR
    send(2'd2, 6'd0, 64'h1);
    track(100);
    chk("n1_done",      t_done,  25);
    chk("n1_tms",       t_tms,   128'h19);
    chk("n1_rsp",       t_rsp,   exp_cap(64'h1));

    // Full-width DR, inverted loopback
    tdo_inv = 1'b1;
    send(2'd2, 6'd63, 64'hDEADBEEF01234567);
    track(400);
    chk("full_done",    t_done,  277);
    chk("full_nrise",   t_nrise, 69);
    chk("full_tms",     t_tms,   (128'd1 | (128'd1 << 66) | (128'd1 << 67)));
    chk("full_tdi",     t_tdi,   (128'hDEADBEEF01234567 << 3));
    chk("full_rsp",     t_rsp,   exp_cap(64'h2152_4110_FEDC_BA98));

    // RESET command pulses rsp_vld and clears rsp_data
    tdo_inv = 1'b0;
    send(2'd0, 6'd9, 64'h55);
    track(100);
    chk("reset_done",   t_done,     25);
    chk("reset_tms",    t_tms,      128'h1F);
    chk("reset_vld",    t_vld_done, 1);
    chk("reset_rsp",    t_rsp,      0);

    // IDLE for 3 TCKs
    send(2'd3, 6'd2, 64'hFF);
    track(100);
    chk("idle_done",    t_done,     13);
    chk("idle_nrise",   t_nrise,    3);
    chk("idle_tms",     t_tms,      0);
    chk("idle_tdi",     t_tdi,      0);
    chk("idle_vld",     t_vld_done, 1);

    // Reset during shift bit 3 of a DR
    send(2'd2, 6'd7, 64'hA5);
    repeat (27) @(negedge clk);
    chk("abort_pre_tck", tck, 1);
    chk("abort_pre_tms", tms, 0);
    rst_l = 1'b0;
    @(negedge clk);
    chk("abort_tck",     tck,      0);
    chk("abort_tms",     tms,      1);
    chk("abort_rdy",     cmd_rdy,  0);
    chk("abort_vld",     rsp_vld,  0);
    chk("abort_rsp",     rsp_data, 0);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    track(100);
    chk("abort_auto_done", t_done,    25);
    chk("abort_auto_vld",  t_vld_cnt, 0);
    chk("abort_auto_rsp",  t_rsp,     0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
